// File: rtl/seg7_reader.sv
// seg7_reader: samples a 7-segment bus, debounces each pattern, decodes it
// to a hex symbol and queues symbols in a small FIFO for a ready/valid consumer.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       overflow,
  output logic [7:0] commit_count
);

  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } sym_t;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK   = 7'h00;

  logic [6:0] sample, cand, commit_pat, last_pat;
  logic [7:0] cnt;
  logic       commit_q;

  sym_t       mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] occ;

  sym_t dec;
  logic push, pop, full, accept;

  // Input sample stage plus stability tracking; commit is registered so the
  // committed pattern is held even if the candidate changes on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample     <= BLANK;
      cand       <= BLANK;
      cnt        <= '0;
      commit_q   <= 1'b0;
      commit_pat <= BLANK;
    end else begin
      sample   <= seg_in;
      commit_q <= 1'b0;
      if (sample != cand) begin
        cand <= sample;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
        if (cnt == CNT_MAX - 8'd1) begin
          commit_q   <= 1'b1;
          commit_pat <= cand;
        end
      end
    end
  end

  // Hex decode of the committed pattern; anything unknown is flagged as err.
  always_comb begin
    dec = '{err: 1'b0, digit: 4'h0};
    case (commit_pat)
      7'h3F: dec.digit = 4'h0;
      7'h06: dec.digit = 4'h1;
      7'h5B: dec.digit = 4'h2;
      7'h4F: dec.digit = 4'h3;
      7'h66: dec.digit = 4'h4;
      7'h6D: dec.digit = 4'h5;
      7'h7D: dec.digit = 4'h6;
      7'h07: dec.digit = 4'h7;
      7'h7F: dec.digit = 4'h8;
      7'h6F: dec.digit = 4'h9;
      7'h77: dec.digit = 4'hA;
      7'h7C: dec.digit = 4'hB;
      7'h39: dec.digit = 4'hC;
      7'h5E: dec.digit = 4'hD;
      7'h79: dec.digit = 4'hE;
      7'h71: dec.digit = 4'hF;
      default: dec.err = 1'b1;
    endcase
  end

  // Blank and repeats of the previous commit never push.
  always_comb begin
    full   = (occ == 3'd4);
    pop    = (occ != 3'd0) && out_ready;
    push   = commit_q && (commit_pat != BLANK) && (commit_pat != last_pat);
    accept = push && (!full || pop);
  end

  // Last-committed tracking, FIFO pointers, overflow flag and commit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pat     <= BLANK;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow     <= 1'b0;
      commit_count <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (commit_q) last_pat <= commit_pat;
      if (accept) begin
        mem[wr_ptr]  <= dec;
        wr_ptr       <= wr_ptr + 2'd1;
        commit_count <= commit_count + 8'd1;
      end
      if (push && !accept) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({accept, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Head presentation; zeros when empty.
  always_comb begin
    out_valid = (occ != 3'd0);
    out_digit = out_valid ? mem[rd_ptr].digit : 4'h0;
    out_err   = out_valid ? mem[rd_ptr].err   : 1'b0;
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with an expected-symbol scoreboard.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       out_valid, out_ready, out_err, overflow;
  logic [3:0] out_digit;
  logic [7:0] commit_count;

  int ncmp = 0;
  int nfail = 0;
  logic [4:0] sb [$];   // {err, digit}

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_digit(out_digit), .out_err(out_err),
    .overflow(overflow), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    step(n);
  endtask

  // Pop every expected symbol in order, then confirm the FIFO is empty.
  task automatic drain(input string tag);
    logic [4:0] e;
    int w;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      w = 0;
      while (!out_valid && w < 20) begin step(1); w++; end
      chk({tag, "_valid"}, 8'(out_valid), 8'd1);
      chk({tag, "_digit"}, 8'(out_digit), 8'(e[3:0]));
      chk({tag, "_err"},   8'(out_err),   8'(e[4]));
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
    end
    chk({tag, "_empty"}, 8'(out_valid), 8'd0);
  endtask

  initial begin
    rst = 1'b1; seg_in = 7'h00; out_ready = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_digit", 8'(out_digit), 8'd0);
    chk("rst_err",   8'(out_err),   8'd0);
    chk("rst_ovf",   8'(overflow),  8'd0);
    chk("rst_cnt",   commit_count,  8'd0);

    // Latency: out_valid rises exactly 6 edges after seg_in changes.
    seg_in = 7'h5B;
    sb.push_back({1'b0, 4'h2});
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk($sformatf("lat_e%0d", i), 8'(out_valid), (i == 6) ? 8'd1 : 8'd0);
    end
    hold(7'h5B, 4);
    chk("d2_digit", 8'(out_digit), 8'd2);
    chk("d2_cnt",   commit_count,  8'd1);
    drain("d2");

    // Too-short 06 is never committed.
    hold(7'h06, 3);
    sb.push_back({1'b0, 4'h3});
    hold(7'h4F, 8);
    drain("short");
    chk("short_cnt", commit_count, 8'd2);

    // Blank gap separates repeated digits.
    sb.push_back({1'b0, 4'h0});
    hold(7'h3F, 8);
    hold(7'h00, 5);
    sb.push_back({1'b0, 4'h0});
    hold(7'h3F, 8);
    drain("gap");
    hold(7'h3F, 8);
    chk("nogap_none", 8'(out_valid), 8'd0);

    // Unrecognised pattern.
    sb.push_back({1'b0, 4'h8});
    hold(7'h7F, 8);
    sb.push_back({1'b1, 4'h0});
    hold(7'h01, 8);
    drain("err");
    chk("err_cnt", commit_count, 8'd6);

    // Overflow: six digits into a 4-deep FIFO.
    rst = 1'b1; step(1); rst = 0;
    sb.push_back({1'b0, 4'h1}); hold(7'h06, 6);
    sb.push_back({1'b0, 4'h2}); hold(7'h5B, 6);
    sb.push_back({1'b0, 4'h3}); hold(7'h4F, 6);
    sb.push_back({1'b0, 4'h4}); hold(7'h66, 6);
    hold(7'h6D, 6);
    hold(7'h7D, 6);
    step(4);
    chk("ovf_flag", 8'(overflow), 8'd1);
    chk("ovf_cnt",  commit_count, 8'd4);
    drain("ovf");
    chk("ovf_sticky", 8'(overflow), 8'd1);

    // Reset with two entries queued and a commit due on the reset edge.
    sb.push_back({1'b0, 4'h1}); hold(7'h06, 6);
    sb.push_back({1'b0, 4'h2}); hold(7'h5B, 6);
    chk("pre_rst_cnt", commit_count, 8'd6);
    hold(7'h4F, 5);
    rst = 1'b1; step(1); rst = 1'b0;
    sb.delete();
    chk("mid_rst_valid", 8'(out_valid), 8'd0);
    chk("mid_rst_cnt",   commit_count,  8'd0);
    chk("mid_rst_ovf",   8'(overflow),  8'd0);
    sb.push_back({1'b0, 4'h3});
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk($sformatf("relat_e%0d", i), 8'(out_valid), (i == 6) ? 8'd1 : 8'd0);
    end
    drain("rerst");
    chk("rerst_cnt", commit_count, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive sampled cycles a segment pattern must hold before it is committed.
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port seg_in  input  7  segment pattern from the display driver, bit0=a .. bit6=g, active-high.
REQ-005 SHALL have port out_valid  output  1  FIFO head holds a decoded symbol.
REQ-006 SHALL have port out_ready  input  1  consumer accepts the head symbol.
REQ-007 SHALL have port out_digit  output  4  decoded hex value of the head symbol.
REQ-008 SHALL have port out_err  output  1  head symbol was an unrecognised pattern.
REQ-009 SHALL have port overflow  output  1  sticky: a commit was dropped because the FIFO was full.
REQ-010 SHALL have port commit_count  output  8  number of symbols accepted into the FIFO, wraps 255->0.

Function
REQ-011 SHALL register seg_in into a sample register every cycle (one-stage input pipeline).
REQ-012 SHALL keep a candidate pattern and stability counter: if sample != candidate, load candidate<=sample and counter<=0; else increment counter, saturating at STABLE_CYCLES-1.
REQ-013 SHALL raise an internal commit exactly once per stable run, in the cycle the counter transitions to STABLE_CYCLES-1.
REQ-014 SHALL hold a last_committed pattern; a commit equal to last_committed pushes nothing.
REQ-015 SHALL treat blank (7'h00) as a separator: a blank commit sets last_committed=blank and pushes nothing, so a repeated digit after a blank is pushed again.
REQ-016 SHALL decode standard hex patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; matching pushes {err=0,digit}.
REQ-017 SHALL push {err=1,digit=0} for any non-blank pattern not in the table; last_committed updates as usual.
REQ-018 SHALL buffer symbols in a 4-entry FIFO; out_valid=1 iff non-empty; out_digit/out_err reflect the head (0 when empty).
REQ-019 SHALL pop the head on a cycle with out_valid && out_ready.
REQ-020 SHALL, on push while full without pop, drop the symbol, set overflow, leave commit_count unchanged.
REQ-021 SHALL, on push and pop in the same cycle (including when full), perform both; occupancy unchanged, push accepted.
REQ-022 SHALL increment commit_count (mod 256) on every accepted push.
REQ-023 SHALL, with an empty FIFO, assert out_valid exactly STABLE_CYCLES+2 rising edges after the edge at which seg_in first presents a new stable pattern.
REQ-024 SHALL ignore out_ready while out_valid=0.

Reset
REQ-025 SHALL on rst: out_valid=0, out_digit=0, out_err=0, overflow=0, commit_count=0, FIFO empty, sample=candidate=last_committed=blank, counter=0.
REQ-026 SHALL let rst override all activity in the same edge, including a pending commit or pop; no partial state survives.
REQ-027 SHALL clear overflow only by rst.

Verification
REQ-028 SHALL cover: seg_in=7'h5B held 10 cycles, out_ready=0 -> out_valid rises 6 edges after settle, out_digit=2, out_err=0, commit_count=1, single entry.
REQ-029 SHALL cover: 7'h06 for 3 cycles then 7'h4F held -> no symbol for 06; one symbol digit=3.
REQ-030 SHALL cover: 7'h3F held, then 7'h00 held 5 cycles, then 7'h3F held -> two symbols digit=0; without the blank gap only one.
REQ-031 SHALL cover: 7'h7F held -> err path: 7'h01 held gives out_err=1, out_digit=0.
REQ-032 SHALL cover: six distinct digits 1..6 each held 6 cycles with out_ready=0 -> FIFO holds 1,2,3,4, overflow=1, commit_count=4; then out_ready=1 drains 1,2,3,4 in order.
REQ-033 SHALL cover: rst pulsed one cycle while FIFO holds 2 entries and a commit is due -> next cycle out_valid=0, commit_count=0, overflow=0; same stable digit re-held is pushed again after STABLE_CYCLES+2 edges.
